// File: rtl/updown_counter_n.sv
// updown_counter_n: prescaled up/down counter with load, programmable step, wrap/saturate mode and event flags
module updown_counter_n #(
  parameter int WIDTH       = 16,
  parameter int STEP_WIDTH  = 4,
  parameter int PRESCALE    = 1,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  load_,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  enable,
  input  logic                  up,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  clear_flags,
  output logic [WIDTH-1:0]      out,
  output logic                  tick,
  output logic                  wrapped,
  output logic                  overflow_sticky,
  output logic                  underflow_sticky
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  if (STEP_WIDTH < 1 || STEP_WIDTH > WIDTH || PRESCALE < 1 || SATURATE < 0 || SATURATE > 1 ||
      RESET_VALUE < 0 || (RESET_VALUE >> WIDTH) != 0) begin : g_bad_params
    $error("updown_counter_n: invalid parameter combination");
  end
  logic [PW-1:0] pre;
  logic [WIDTH:0] ext, res;
  logic [WIDTH-1:0] nxt;
  logic apply, carry, hit_ov, hit_un;
  // one extra bit on the result: carry on up, borrow on down
  always_comb begin
    ext    = (WIDTH+1)'(step);
    res    = up ? {1'b0, out} + ext : {1'b0, out} - ext;
    carry  = res[WIDTH];
    apply  = load_ && enable && pre == PW'(PRESCALE-1);
    hit_ov = apply && up && carry;
    hit_un = apply && !up && carry;
    nxt    = (carry && SATURATE != 0) ? {WIDTH{up}} : res[WIDTH-1:0];
  end
  always_ff @(posedge clock) begin
    if (!reset_) begin
      out              <= WIDTH'(RESET_VALUE);
      pre              <= '0;
      tick             <= 1'b0;
      wrapped          <= 1'b0;
      overflow_sticky  <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      overflow_sticky  <= hit_ov | (overflow_sticky & ~clear_flags);
      underflow_sticky <= hit_un | (underflow_sticky & ~clear_flags);
      tick             <= apply;
      wrapped          <= apply & carry;
      if (!load_) begin
        out <= load_value;
        pre <= '0;
      end else if (apply) begin
        out <= nxt;
        pre <= '0;
      end else if (enable) pre <= pre + 1'b1;
    end
  end
endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: four counter configurations driven in lockstep and scored against an integer model
module tb_updown_counter_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_ = 1'b0, load_ = 1'b1, enable = 1'b0, up = 1'b1, clear_flags = 1'b0;
  logic [3:0] load_value = '0, step = '0;
  logic [3:0] out_v [4];
  logic tick_v [4], wr_v [4], ov_v [4], un_v [4];
  int ps  [4] = '{1, 1, 3, 4};
  int sat [4] = '{0, 1, 0, 0};
  int rv  [4] = '{0, 0, 0, 3};
  int m_cnt [4], m_pre [4];
  bit m_t [4], m_w [4], m_ov [4], m_un [4];
  logic [31:0] sb [$];
  int compared = 0, mismatched = 0;

  updown_counter_n #(.WIDTH(4), .STEP_WIDTH(4), .PRESCALE(1), .SATURATE(0), .RESET_VALUE(0)) u0 (
    .clock(clk), .reset_(reset_), .load_(load_), .load_value(load_value), .enable(enable), .up(up),
    .step(step), .clear_flags(clear_flags), .out(out_v[0]), .tick(tick_v[0]), .wrapped(wr_v[0]),
    .overflow_sticky(ov_v[0]), .underflow_sticky(un_v[0]));
  updown_counter_n #(.WIDTH(4), .STEP_WIDTH(4), .PRESCALE(1), .SATURATE(1), .RESET_VALUE(0)) u1 (
    .clock(clk), .reset_(reset_), .load_(load_), .load_value(load_value), .enable(enable), .up(up),
    .step(step), .clear_flags(clear_flags), .out(out_v[1]), .tick(tick_v[1]), .wrapped(wr_v[1]),
    .overflow_sticky(ov_v[1]), .underflow_sticky(un_v[1]));
  updown_counter_n #(.WIDTH(4), .STEP_WIDTH(4), .PRESCALE(3), .SATURATE(0), .RESET_VALUE(0)) u2 (
    .clock(clk), .reset_(reset_), .load_(load_), .load_value(load_value), .enable(enable), .up(up),
    .step(step), .clear_flags(clear_flags), .out(out_v[2]), .tick(tick_v[2]), .wrapped(wr_v[2]),
    .overflow_sticky(ov_v[2]), .underflow_sticky(un_v[2]));
  updown_counter_n #(.WIDTH(4), .STEP_WIDTH(4), .PRESCALE(4), .SATURATE(0), .RESET_VALUE(3)) u3 (
    .clock(clk), .reset_(reset_), .load_(load_), .load_value(load_value), .enable(enable), .up(up),
    .step(step), .clear_flags(clear_flags), .out(out_v[3]), .tick(tick_v[3]), .wrapped(wr_v[3]),
    .overflow_sticky(ov_v[3]), .underflow_sticky(un_v[3]));

  task automatic cyc(input string tag, input bit rn, input bit ld, input int lv, input bit en,
                     input bit u, input int st, input bit clr, input int n = 1);
    for (int k = 0; k < n; k++) begin
      logic [31:0] e;
      logic [7:0] ob;
      bit fo, fu;
      int r;
      reset_ = rn; load_ = ld; load_value = 4'(lv); enable = en; up = u; step = 4'(st); clear_flags = clr;
      for (int i = 0; i < 4; i++) begin
        if (!rn) begin
          m_cnt[i] = rv[i]; m_pre[i] = 0; m_t[i] = 0; m_w[i] = 0; m_ov[i] = 0; m_un[i] = 0;
        end else begin
          fo = 0; fu = 0; m_t[i] = 0;
          if (!ld) begin
            m_cnt[i] = lv; m_pre[i] = 0;
          end else if (en) begin
            if (m_pre[i] == ps[i] - 1) begin
              m_pre[i] = 0; m_t[i] = 1;
              r = u ? m_cnt[i] + st : m_cnt[i] - st;
              fo = r > 15; fu = r < 0;
              m_cnt[i] = fo ? (sat[i] != 0 ? 15 : r - 16) : fu ? (sat[i] != 0 ? 0 : r + 16) : r;
            end else m_pre[i]++;
          end
          m_w[i]  = fo | fu;
          m_ov[i] = fo | (m_ov[i] & !clr);
          m_un[i] = fu | (m_un[i] & !clr);
        end
        e[i*8 +: 8] = {4'(m_cnt[i]), m_t[i], m_w[i], m_ov[i], m_un[i]};
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        ob = {out_v[i], tick_v[i], wr_v[i], ov_v[i], un_v[i]};
        compared++;
        assert (ob === e[i*8 +: 8]) else begin
          mismatched++;
          $error("FAIL %s u%0d: got out=%0d tick=%b wrap=%b ovf=%b unf=%b, expected out=%0d tick=%b wrap=%b ovf=%b unf=%b",
                 tag, i, ob[7:4], ob[3], ob[2], ob[1], ob[0], e[i*8+4 +: 4], e[i*8+3], e[i*8+2], e[i*8+1], e[i*8]);
        end
      end
    end
  endtask

  initial begin
    //   tag          rn ld lv en up st clr n
    cyc("reset",       0, 1, 0, 0, 1, 1, 0);
    compared++;
    assert (out_v[3] === 4'd3) else begin
      mismatched++;
      $error("FAIL reset_value: got out=%0d expected 3", out_v[3]);
    end
    cyc("count_up",    1, 1, 0, 1, 1, 1, 0, 17);
    cyc("load2",       1, 0, 2, 1, 1, 1, 0);
    cyc("down3",       1, 1, 0, 1, 0, 3, 0, 4);
    cyc("clear",       1, 1, 0, 0, 0, 3, 1);
    cyc("load14",      1, 0, 14, 0, 1, 3, 0);
    cyc("sat_up",      1, 1, 0, 1, 1, 3, 0, 8);
    cyc("sat_down",    1, 1, 0, 1, 0, 15, 0, 8);
    cyc("exact_top",   1, 0, 12, 1, 1, 3, 1);
    cyc("exact_top",   1, 1, 0, 1, 1, 3, 0, 4);
    cyc("en_on",       1, 0, 0, 1, 1, 1, 1);
    cyc("en_on",       1, 1, 0, 1, 1, 1, 0, 3);
    cyc("en_off",      1, 1, 0, 0, 1, 1, 0, 2);
    cyc("en_resume",   1, 1, 0, 1, 1, 1, 0, 6);
    cyc("mid_pre",     1, 1, 0, 1, 1, 1, 0, 2);
    cyc("mid_reset",   0, 1, 0, 1, 1, 1, 0);
    cyc("after_reset", 1, 1, 0, 1, 1, 1, 0, 5);
    cyc("mid_pre2",    1, 1, 0, 1, 0, 5, 0, 2);
    cyc("mid_load",    1, 0, 9, 1, 0, 5, 0);
    cyc("after_load",  1, 1, 0, 1, 0, 5, 0, 5);
    cyc("step_zero",   1, 1, 0, 1, 1, 0, 0, 5);
    cyc("ovf_clr",     1, 0, 15, 1, 1, 1, 1);
    cyc("ovf_clr",     1, 1, 0, 1, 1, 1, 1, 4);
    cyc("load_clr",    1, 0, 1, 1, 0, 2, 1);
    cyc("unf",         1, 1, 0, 1, 0, 2, 0, 4);
    cyc("load_keep",   1, 0, 6, 1, 0, 2, 0);
    cyc("rst_and_ld",  0, 0, 7, 1, 1, 1, 0);
    for (int k = 0; k < 60; k++)
      cyc("random", $urandom_range(15) != 0, $urandom_range(7) != 0, $urandom_range(15),
          $urandom_range(3) != 0, $urandom_range(1), $urandom_range(15), $urandom_range(5) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
